// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO controller among NUM_REQ requesters.
// Latches the winner's frame, pulses mdio_start, then returns read data or a timeout error.
module mdio_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 128,
  parameter int TW      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [15:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  mdio_start,
  output logic [31:0]           t_data,
  input  logic                  data_rdy,
  input  logic [15:0]           rd_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        rr_ptr, rr_nxt;
  logic [PW-1:0]        own_idx, own_nxt;
  logic [TW-1:0]        tmo_cnt, tmo_nxt;
  logic [NUM_REQ-1:0]   grant_nxt, done_nxt;
  logic [15:0]          rsp_data_nxt;
  logic                 rsp_err_nxt;
  logic                 start_nxt;
  logic [31:0]          t_data_nxt;

  logic                 win_vld;
  logic [PW-1:0]        win_idx;
  int                   scan_idx;

  // Winner: first requesting port at or above rr_ptr, wrapping around.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = PW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr_ptr;
    own_nxt      = own_idx;
    tmo_nxt      = tmo_cnt;
    grant_nxt    = grant;
    done_nxt     = '0;
    rsp_data_nxt = rsp_data;
    rsp_err_nxt  = rsp_err;
    start_nxt    = 1'b0;
    t_data_nxt   = t_data;
    case (state)
      IDLE: begin
        if (win_vld) begin
          grant_nxt  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          t_data_nxt = req_data[32*win_idx +: 32];
          start_nxt  = 1'b1;
          tmo_nxt    = '0;
          own_nxt    = win_idx;
          state_nxt  = START;
        end
      end
      START: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        tmo_nxt = tmo_cnt + 1'b1;
        // A completion that coincides with the timeout cycle still counts as good data.
        if (data_rdy) begin
          rsp_data_nxt = rd_data;
          rsp_err_nxt  = 1'b0;
          done_nxt     = grant;
          state_nxt    = DONE;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          rsp_data_nxt = 16'hFFFF;
          rsp_err_nxt  = 1'b1;
          done_nxt     = grant;
          state_nxt    = DONE;
        end
      end
      DONE: begin
        grant_nxt = '0;
        rr_nxt    = (own_idx == PW'(NUM_REQ - 1)) ? '0 : PW'(own_idx + 1'b1);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      own_idx    <= '0;
      tmo_cnt    <= '0;
      grant      <= '0;
      done       <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      mdio_start <= 1'b0;
      t_data     <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      own_idx    <= own_nxt;
      tmo_cnt    <= tmo_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      rsp_data   <= rsp_data_nxt;
      rsp_err    <= rsp_err_nxt;
      mdio_start <= start_nxt;
      t_data     <= t_data_nxt;
    end
  end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed bench for mdio_arbiter: scoreboard of expected transaction results,
// compared when done pulses; invariants checked every cycle.
module tb_mdio_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 128;
  localparam int TW      = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic [15:0]           rsp_data;
  logic                  rsp_err;
  logic                  mdio_start;
  logic [31:0]           t_data;
  logic                  data_rdy;
  logic [15:0]           rd_data;

  mdio_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mdio_start(mdio_start), .t_data(t_data), .data_rdy(data_rdy), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0] who;
    logic [15:0]        data;
    logic               err;
    logic [31:0]        frame;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   start_cyc = 0;
  int   done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Structural invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
      chk("done_in_grant", 64'(done & ~grant), 64'd0);
      if (mdio_start) n_start++;
    end
  end

  task automatic push(input logic [NUM_REQ-1:0] who, input logic [15:0] d,
                      input logic e, input logic [31:0] f);
    exp_t x;
    x.who = who; x.data = d; x.err = e; x.frame = f;
    exp_q.push_back(x);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!mdio_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mdio_start) begin
      chk("start_seen", 64'd0, 64'd1);
    end else begin
      start_cyc = cyc;
      chk("start_grant", 64'(grant), 64'(exp_q[0].who));
      chk("start_t_data", 64'(t_data), 64'(exp_q[0].frame));
    end
  endtask

  task automatic pulse_rdy(input logic [15:0] v);
    data_rdy = 1'b1;
    rd_data  = v;
    @(negedge clk);
    data_rdy = 1'b0;
    rd_data  = 16'h0;
  endtask

  // Polls from the current falling edge; the requester drops req on done.
  task automatic wait_done(input logic [NUM_REQ-1:0] keep_req);
    int n = 0;
    exp_t x;
    while (done == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done == '0) begin
      chk("done_seen", 64'd0, 64'd1);
    end else begin
      done_cyc = cyc;
      x = exp_q.pop_front();
      chk("done_bits", 64'(done), 64'(x.who));
      chk("rsp_data", 64'(rsp_data), 64'(x.data));
      chk("rsp_err", 64'(rsp_err), 64'(x.err));
      req = keep_req;
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("grant_released", 64'(grant), 64'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    req      = '1;
    req_data = {32'hDEAD_0001, 32'hDEAD_0000};
    data_rdy = 1'b0;
    rd_data  = 16'h0;

    // Reset held 3 cycles with every port requesting.
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_start", 64'(mdio_start), 64'd0);
    chk("rst_t_data", 64'(t_data), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    req   = '0;
    reset = 1'b0;
    @(negedge clk);

    // Single read on port 0; frame changed after grant must not reach t_data.
    req_data = {32'h1111_2222, 32'h6082_0000};
    req      = 2'b01;
    push(2'b01, 16'hBEEF, 1'b0, 32'h6082_0000);
    wait_start();
    req_data[31:0] = 32'h0BAD_F00D;
    repeat (4) @(negedge clk);
    chk("t_data_latched", 64'(t_data), 64'h6082_0000);
    @(negedge clk);
    pulse_rdy(16'hBEEF);
    wait_done(2'b00);

    // Both ports held: rr_ptr is 1 after the port-0 read, so grants go 10,01,10,01.
    req_data = {32'hA1A1_0001, 32'hB0B0_0000};
    req      = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push(2'b10, 16'h1000 + 16'(i), 1'b0, 32'hA1A1_0001);
      else            push(2'b01, 16'h1000 + 16'(i), 1'b0, 32'hB0B0_0000);
      wait_start();
      @(negedge clk);
      pulse_rdy(16'h1000 + 16'(i));
      wait_done((i == 3) ? 2'b00 : 2'b11);
    end

    // Timeout on port 1: done lands TIMEOUT+1 cycles after the start cycle,
    // i.e. TIMEOUT+2 after the cycle in which req was sampled.
    req_data = {32'h6BFF_0000, 32'h0};
    req      = 2'b10;
    push(2'b10, 16'hFFFF, 1'b1, 32'h6BFF_0000);
    wait_start();
    wait_done(2'b00);
    chk("timeout_latency", 64'(done_cyc - start_cyc), 64'(TIMEOUT + 1));

    // data_rdy on the exact timeout cycle wins over the timeout.
    req_data = {32'h6C00_0000, 32'h0};
    req      = 2'b10;
    push(2'b10, 16'hCAFE, 1'b0, 32'h6C00_0000);
    wait_start();
    repeat (TIMEOUT) @(negedge clk);
    pulse_rdy(16'hCAFE);
    wait_done(2'b00);

    // data_rdy during START is ignored.
    req_data = {32'h0, 32'h6D00_0000};
    req      = 2'b01;
    push(2'b01, 16'h1234, 1'b0, 32'h6D00_0000);
    wait_start();
    pulse_rdy(16'h5555);
    chk("start_rdy_ignored_a", 64'(done), 64'd0);
    @(negedge clk);
    chk("start_rdy_ignored_b", 64'(done), 64'd0);
    pulse_rdy(16'h1234);
    wait_done(2'b00);

    // Reset 3 cycles into WAIT: no done, grant cleared, rr_ptr back to 0.
    req_data = {32'h7000_0001, 32'h7000_0000};
    req      = 2'b01;
    push(2'b01, 16'h0, 1'b0, 32'h7000_0000);
    wait_start();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    req   = 2'b00;
    void'(exp_q.pop_front());
    @(negedge clk);
    chk("rst_wait_grant", 64'(grant), 64'd0);
    chk("rst_wait_done", 64'(done), 64'd0);
    chk("rst_wait_start", 64'(mdio_start), 64'd0);
    reset = 1'b0;
    req   = 2'b11;
    push(2'b01, 16'h4242, 1'b0, 32'h7000_0000);
    wait_start();
    @(negedge clk);
    pulse_rdy(16'h4242);
    wait_done(2'b00);

    repeat (3) @(negedge clk);
    chk("start_pulses", 64'(n_start), 64'd10);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
